// File: rtl/wd_pkg.sv
// rtl/wd_pkg.sv - shared state encoding, fail codes and helpers for the watchdog service controller
package wd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLOSED = 3'd1,
        ST_OPEN   = 3'd2,
        ST_FAIL   = 3'd3,
        ST_HOLD   = 3'd4,
        ST_LOCK   = 3'd5
    } wd_state_t;

    localparam logic [1:0] FC_OVERRIDE  = 2'b00;
    localparam logic [1:0] FC_EARLY     = 2'b01;
    localparam logic [1:0] FC_UNHEALTHY = 2'b10;
    localparam logic [1:0] FC_TIMEOUT   = 2'b11;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/wd_window_timer.sv
// rtl/wd_window_timer.sv - 16-bit window counter with open/close compare flags
module wd_window_timer #(
    parameter int WIN_OPEN  = 16,
    parameter int WIN_CLOSE = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic at_open,
    output logic at_close
);

    logic [15:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 16'd1;
        end
    end

    assign at_open  = (cnt == 16'(WIN_OPEN - 1));
    assign at_close = (cnt == 16'(WIN_CLOSE - 1));

endmodule

// File: rtl/wd_service_ctrl.sv
// rtl/wd_service_ctrl.sv - windowed watchdog service FSM with fail latching, reset hold and lockout
module wd_service_ctrl
    import wd_pkg::*;
#(
    parameter int WIN_OPEN  = 16,
    parameter int WIN_CLOSE = 64,
    parameter int RST_HOLD  = 8,
    parameter int MAX_FAIL  = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       swstat,
    input  logic       srvc_req,
    input  logic       fwovr_req,
    input  logic       wdfail,
    input  logic [1:0] flstat,
    output logic       wdsrvc,
    output logic       fwovr,
    output logic       sys_rst,
    output logic [1:0] fail_code,
    output logic [3:0] fail_cnt,
    output logic [2:0] state
);

    wd_state_t   state_q;
    logic [15:0] hold_cnt;
    logic        in_window;
    logic        kick_ok;
    logic        at_open;
    logic        at_close;

    assign in_window = (state_q == ST_CLOSED) || (state_q == ST_OPEN);
    // Counter restarts on an accepted kick; outside the window it is held at zero.
    assign kick_ok   = (state_q == ST_OPEN) && !fwovr_req && !wdfail && en && srvc_req && swstat;
    assign state     = state_q;

    wd_window_timer #(
        .WIN_OPEN (WIN_OPEN),
        .WIN_CLOSE(WIN_CLOSE)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (!in_window || kick_ok),
        .en      (in_window),
        .at_open (at_open),
        .at_close(at_close)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            wdsrvc    <= 1'b0;
            fwovr     <= 1'b0;
            sys_rst   <= 1'b0;
            fail_code <= FC_OVERRIDE;
            fail_cnt  <= 4'd0;
            hold_cnt  <= '0;
        end else begin
            wdsrvc <= 1'b0;
            fwovr  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (en) state_q <= ST_CLOSED;
                end
                ST_CLOSED, ST_OPEN: begin
                    if (fwovr_req) begin
                        fwovr     <= 1'b1;
                        fail_code <= FC_OVERRIDE;
                        state_q   <= ST_FAIL;
                    end else if (wdfail) begin
                        fail_code <= flstat;
                        state_q   <= ST_FAIL;
                    end else if (!en) begin
                        state_q <= ST_IDLE;
                    end else if (srvc_req) begin
                        if (state_q == ST_CLOSED) begin
                            fail_code <= FC_EARLY;
                            state_q   <= ST_FAIL;
                        end else if (swstat) begin
                            wdsrvc  <= 1'b1;
                            state_q <= ST_CLOSED;
                        end else begin
                            fail_code <= FC_UNHEALTHY;
                            state_q   <= ST_FAIL;
                        end
                    end else if (state_q == ST_CLOSED && at_open) begin
                        state_q <= ST_OPEN;
                    end else if (state_q == ST_OPEN && at_close) begin
                        fail_code <= FC_TIMEOUT;
                        state_q   <= ST_FAIL;
                    end
                end
                ST_FAIL: begin
                    fail_cnt <= sat_inc(fail_cnt);
                    sys_rst  <= 1'b1;
                    hold_cnt <= '0;
                    state_q  <= (sat_inc(fail_cnt) >= 4'(MAX_FAIL)) ? ST_LOCK : ST_HOLD;
                end
                ST_HOLD: begin
                    if (hold_cnt == 16'(RST_HOLD - 1)) begin
                        sys_rst <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        hold_cnt <= hold_cnt + 16'd1;
                    end
                end
                ST_LOCK: begin
                    sys_rst <= 1'b1;
                end
                default: begin
                    sys_rst <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wd_service_ctrl.sv
// tb/tb_wd_service_ctrl.sv - directed and randomized checks of wd_service_ctrl against a window-age model
module tb_wd_service_ctrl;
    import wd_pkg::*;

    localparam int WO = 4;
    localparam int WC = 8;
    localparam int RH = 3;
    localparam int MF = 2;

    localparam int M_IDLE = 0;
    localparam int M_WIN  = 1;
    localparam int M_FAIL = 2;
    localparam int M_HOLD = 3;
    localparam int M_LOCK = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       swstat = 1'b1;
    logic       srvc_req = 1'b0;
    logic       fwovr_req = 1'b0;
    logic       wdfail = 1'b0;
    logic [1:0] flstat = 2'b00;
    logic       wdsrvc;
    logic       fwovr;
    logic       sys_rst;
    logic [1:0] fail_code;
    logic [3:0] fail_cnt;
    logic [2:0] state;

    int n_checks = 0;
    int n_fail = 0;

    int         m_st;
    int         m_age;
    int         m_hold_left;
    logic       m_wdsrvc;
    logic       m_fwovr;
    logic       m_sysrst;
    logic [1:0] m_code;
    logic [3:0] m_cnt;

    wd_service_ctrl #(
        .WIN_OPEN (WO),
        .WIN_CLOSE(WC),
        .RST_HOLD (RH),
        .MAX_FAIL (MF)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .swstat   (swstat),
        .srvc_req (srvc_req),
        .fwovr_req(fwovr_req),
        .wdfail   (wdfail),
        .flstat   (flstat),
        .wdsrvc   (wdsrvc),
        .fwovr    (fwovr),
        .sys_rst  (sys_rst),
        .fail_code(fail_code),
        .fail_cnt (fail_cnt),
        .state    (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] dut_vec();
        return {20'd0, state, wdsrvc, fwovr, sys_rst, fail_code, fail_cnt};
    endfunction

    function automatic logic [2:0] exp_state();
        case (m_st)
            M_WIN:   return (m_age < WO) ? ST_CLOSED : ST_OPEN;
            M_FAIL:  return ST_FAIL;
            M_HOLD:  return ST_HOLD;
            M_LOCK:  return ST_LOCK;
            default: return ST_IDLE;
        endcase
    endfunction

    function automatic logic [31:0] exp_vec();
        return {20'd0, exp_state(), m_wdsrvc, m_fwovr, m_sysrst, m_code, m_cnt};
    endfunction

    task automatic model_reset();
        m_st = M_IDLE; m_age = 0; m_hold_left = 0;
        m_wdsrvc = 1'b0; m_fwovr = 1'b0; m_sysrst = 1'b0;
        m_code = 2'b00; m_cnt = 4'd0;
    endtask

    task automatic m_fail(input logic [1:0] code);
        m_code = code;
        m_st   = M_FAIL;
    endtask

    // The window is one run of ages 0..WC-1: below WO it is closed, from WO it is open.
    task automatic model_step();
        m_wdsrvc = 1'b0;
        m_fwovr  = 1'b0;
        case (m_st)
            M_IDLE: if (en) begin m_st = M_WIN; m_age = 0; end
            M_WIN: begin
                if (fwovr_req) begin
                    m_fwovr = 1'b1; m_fail(2'b00);
                end else if (wdfail) begin
                    m_fail(flstat);
                end else if (!en) begin
                    m_st = M_IDLE;
                end else if (srvc_req) begin
                    if (m_age < WO) m_fail(2'b01);
                    else if (swstat) begin m_wdsrvc = 1'b1; m_age = 0; end
                    else m_fail(2'b10);
                end else begin
                    m_age++;
                    if (m_age == WC) m_fail(2'b11);
                end
            end
            M_FAIL: begin
                if (m_cnt != 4'd15) m_cnt = m_cnt + 4'd1;
                m_sysrst = 1'b1;
                if (int'(m_cnt) >= MF) m_st = M_LOCK;
                else begin m_st = M_HOLD; m_hold_left = RH; end
            end
            M_HOLD: begin
                m_hold_left--;
                if (m_hold_left == 0) begin m_st = M_IDLE; m_sysrst = 1'b0; end
            end
            default: ;
        endcase
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check(tag, dut_vec(), exp_vec());
    endtask

    task automatic quiet();
        en = 1'b1; swstat = 1'b1; srvc_req = 1'b0; fwovr_req = 1'b0; wdfail = 1'b0; flstat = 2'b00;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        check("reset_async", dut_vec(), exp_vec());
        @(posedge clk);
        #1;
        check("reset_held", dut_vec(), exp_vec());
        rst = 1'b0;
    endtask

    task automatic run_to_age(input int target, input string tag);
        for (int i = 0; i < 100 && !(m_st == M_WIN && m_age == target); i++) cycle(tag);
        if (!(m_st == M_WIN && m_age == target)) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic run_to_state(input int target, input string tag);
        for (int i = 0; i < 100 && m_st != target; i++) cycle(tag);
        if (m_st != target) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        int lock_age;
        int hi;
        model_reset();
        quiet();
        en = 1'b0;
        do_reset();
        cycle("idle_no_en");
        cycle("idle_no_en");

        // Good kick inside the open window
        quiet();
        run_to_age(5, "k39_wait");
        srvc_req = 1'b1;
        cycle("k39_kick");
        srvc_req = 1'b0;
        check("k39_wdsrvc", 32'(wdsrvc), 32'd1);
        check("k39_state", 32'(state), 32'(ST_CLOSED));
        check("k39_failcnt", 32'(fail_cnt), 32'd0);
        cycle("k39_after");
        check("k39_pulse_once", 32'(wdsrvc), 32'd0);

        // Early kick, then reset hold length
        run_to_age(2, "e40_wait");
        srvc_req = 1'b1;
        cycle("e40_kick");
        srvc_req = 1'b0;
        check("e40_code", 32'(fail_code), 32'(FC_EARLY));
        cycle("e40_to_hold");
        check("e40_failcnt", 32'(fail_cnt), 32'd1);
        hi = 0;
        for (int i = 0; i < 10 && sys_rst; i++) begin hi++; cycle("e40_hold"); end
        check("e40_hold_len", 32'(hi), 32'(RH));
        check("e40_idle", 32'(state), 32'(ST_IDLE));

        // Two missed windows lead to lockout
        do_reset();
        quiet();
        run_to_state(M_FAIL, "t41_first");
        check("t41_code", 32'(fail_code), 32'(FC_TIMEOUT));
        cycle("t41_hold");
        check("t41_state_hold", 32'(state), 32'(ST_HOLD));
        run_to_state(M_LOCK, "t41_lock");
        check("t41_failcnt", 32'(fail_cnt), 32'd2);
        for (int i = 0; i < 12; i++) cycle("t41_locked");
        check("t41_sysrst", 32'(sys_rst), 32'd1);

        // Override beats a simultaneous kick
        do_reset();
        quiet();
        run_to_age(5, "o42_wait");
        fwovr_req = 1'b1;
        srvc_req = 1'b1;
        cycle("o42_req");
        quiet();
        check("o42_fwovr", 32'(fwovr), 32'd1);
        check("o42_wdsrvc", 32'(wdsrvc), 32'd0);
        check("o42_code", 32'(fail_code), 32'(FC_OVERRIDE));
        cycle("o42_after");

        // Kick on the last open cycle is accepted
        do_reset();
        quiet();
        run_to_age(WC - 1, "l43_wait");
        srvc_req = 1'b1;
        cycle("l43_kick");
        srvc_req = 1'b0;
        check("l43_wdsrvc", 32'(wdsrvc), 32'd1);
        check("l43_state", 32'(state), 32'(ST_CLOSED));
        cycle("l43_after");

        // Asynchronous reset in the middle of the hold phase
        do_reset();
        quiet();
        run_to_age(1, "r44_wait");
        srvc_req = 1'b1;
        cycle("r44_kick");
        srvc_req = 1'b0;
        cycle("r44_hold1");
        cycle("r44_hold2");
        check("r44_in_hold", 32'(state), 32'(ST_HOLD));
        #2;
        rst = 1'b1;
        #1;
        check("r44_sysrst", 32'(sys_rst), 32'd0);
        check("r44_state", 32'(state), 32'(ST_IDLE));
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Randomized traffic
        lock_age = 0;
        for (int n = 0; n < 4000; n++) begin
            en        = ($urandom_range(0, 39) != 0);
            swstat    = ($urandom_range(0, 7) != 0);
            srvc_req  = ($urandom_range(0, 5) == 0);
            fwovr_req = ($urandom_range(0, 79) == 0);
            wdfail    = ($urandom_range(0, 79) == 0);
            flstat    = 2'($urandom_range(0, 3));
            cycle("rand");
            lock_age = (m_st == M_LOCK) ? lock_age + 1 : 0;
            if (lock_age > 4 || $urandom_range(0, 499) == 0) begin
                do_reset();
                lock_age = 0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wd_service_ctrl.md
WD_SERVICE_CTRL -- requirements
Module: wd_service_ctrl

Interface
REQ-001 Parameter WIN_OPEN, default 16: cycles after window start before service is legal.
REQ-002 Parameter WIN_CLOSE, default 64: cycles after window start at which an unserviced window times out; WIN_CLOSE > WIN_OPEN >= 1.
REQ-003 Parameter RST_HOLD, default 8: cycles SYS_RST is held after a recoverable fail.
REQ-004 Parameter MAX_FAIL, default 3: fail count that forces permanent lock; range 1..15.
REQ-005 CLK  in  1  single clock; all logic on rising edge.
REQ-006 RST  in  1  asynchronous, active-high reset.
REQ-007 EN  in  1  arms the watchdog sequence; low returns it to idle.
REQ-008 SWSTAT  in  1  software health status, synchronous to CLK; 1 = healthy.
REQ-009 SRVC_REQ  in  1  one-cycle software kick request.
REQ-010 FWOVR_REQ  in  1  one-cycle firmware override request.
REQ-011 WDFAIL  in  1  fail flag from the watchdog fail detector.
REQ-012 FLSTAT  in  2  fail code from the watchdog fail detector.
REQ-013 WDSRVC  out  1  one-cycle service pulse to the detector.
REQ-014 FWOVR  out  1  one-cycle override pulse to the detector.
REQ-015 SYS_RST  out  1  system reset request.
REQ-016 FAIL_CODE  out  2  latched cause of the last fail.
REQ-017 FAIL_CNT  out  4  saturating count of fails since RST.
REQ-018 STATE  out  3  current FSM state encoding.

Function
REQ-019 FSM states SHALL be IDLE, CLOSED, OPEN, FAIL, HOLD and LOCK; all outputs registered.
REQ-020 Window counter CNT (16 bit) SHALL clear on entry to CLOSED and increment each cycle in CLOSED and OPEN.
REQ-021 IDLE: EN=1 -> CLOSED with CNT=0; all other inputs ignored.
REQ-022 CLOSED: CNT==WIN_OPEN-1 -> OPEN; SRVC_REQ -> FAIL with FAIL_CODE=01 (early kick).
REQ-023 OPEN: SRVC_REQ with SWSTAT=1 -> WDSRVC high for exactly the next cycle, return to CLOSED, CNT=0.
REQ-024 OPEN: SRVC_REQ with SWSTAT=0 -> FAIL with FAIL_CODE=10, no WDSRVC.
REQ-025 OPEN: CNT==WIN_CLOSE-1 without SRVC_REQ -> FAIL with FAIL_CODE=11 (timeout).
REQ-026 CLOSED/OPEN: WDFAIL=1 -> FAIL with FAIL_CODE=FLSTAT.
REQ-027 CLOSED/OPEN: FWOVR_REQ -> FWOVR high for exactly the next cycle, FAIL with FAIL_CODE=00.
REQ-028 CLOSED/OPEN: EN=0 -> IDLE without fail, FAIL_CNT unchanged.
REQ-029 Same-cycle priority SHALL be FWOVR_REQ > WDFAIL > EN=0 > SRVC_REQ > window count; a kick on the last OPEN cycle is accepted, no timeout.
REQ-030 FAIL (one cycle): FAIL_CNT increments, saturating at 15; new count >= MAX_FAIL -> LOCK, else HOLD.
REQ-031 HOLD: SYS_RST=1 for exactly RST_HOLD cycles, then IDLE with SYS_RST=0.
REQ-032 LOCK: SYS_RST=1 permanently; only RST exits.
REQ-033 FAIL_CODE SHALL hold its value until the next fail or RST.
REQ-034 WDSRVC and FWOVR SHALL never be high in the same cycle, nor high for two consecutive cycles.

Reset
REQ-035 RST=1 SHALL immediately force IDLE, CNT=0, WDSRVC=0, FWOVR=0, SYS_RST=0, FAIL_CODE=00, FAIL_CNT=0, from any state including HOLD and LOCK.
REQ-036 After RST deasserts, the first state change SHALL occur on the first rising CLK edge with EN=1.

Structure
REQ-037 A shared package wd_pkg SHALL hold the state encoding and the fail-code constants (00 override, 01 early, 10 unhealthy, 11 timeout).
REQ-038 One sub-module wd_window_timer SHALL implement CNT with clear, enable and compare-to-WIN_OPEN/WIN_CLOSE flags.

Verification (WIN_OPEN=4, WIN_CLOSE=8, RST_HOLD=3, MAX_FAIL=2)
REQ-039 EN=1, SRVC_REQ with SWSTAT=1 at CNT=5 -> WDSRVC one-cycle pulse, STATE=CLOSED, CNT=0, FAIL_CNT=0.
REQ-040 SRVC_REQ at CNT=2 -> FAIL_CODE=01, FAIL_CNT=1, SYS_RST high 3 cycles, then IDLE.
REQ-041 No kick in two successive windows -> first: FAIL_CODE=11 and HOLD; second: FAIL_CNT=2, LOCK, SYS_RST stays 1 until RST.
REQ-042 FWOVR_REQ and SRVC_REQ together in OPEN -> FWOVR pulse, no WDSRVC, FAIL_CODE=00.
REQ-043 SRVC_REQ at CNT=7 with SWSTAT=1 -> accepted, WDSRVC pulse, no timeout fail.
REQ-044 RST asserted during HOLD cycle 2 -> SYS_RST=0 and STATE=IDLE without waiting for a clock edge.
